// File: rtl/wave_display_if.sv
// ---------------------------------------------------------------------------
// wave_display_if
// Groups the pixel-stream, sample-RAM and status signals of wave_display.
//   x, y, valid        : current VGA raster position and visibility
//   read_index         : RAM half the capture stage marks as stable
//   read_value         : sample RAM data (valid 1 cycle after read_address)
//   read_address       : {active_index, sample_idx} to the sample RAM
//   valid_pixel, r/g/b : pixel colour driven by wave_display
//   wave_display_idle  : beam outside the waveform window (swap allowed)
// modport slave  : the wave_display block
// modport master : the raster source / RAM / pixel consumer side
// ---------------------------------------------------------------------------
interface wave_display_if;
    logic [10:0] x;
    logic [9:0]  y;
    logic        valid;
    logic        read_index;
    logic [7:0]  read_value;
    logic [8:0]  read_address;
    logic        valid_pixel;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        wave_display_idle;

    modport slave (
        input  x, y, valid, read_index, read_value,
        output read_address, valid_pixel, r, g, b, wave_display_idle
    );

    modport master (
        output x, y, valid, read_index, read_value,
        input  read_address, valid_pixel, r, g, b, wave_display_idle
    );
endinterface

// File: rtl/wave_display.sv
// ---------------------------------------------------------------------------
// wave_display
// Converts the double-buffered 512-entry sample RAM into a connected
// waveform trace (256 samples, 2 px each) inside a 512x512 window of the
// VGA raster. Pixel outputs follow x/y by exactly two clocks.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : wave_display_if.slave (raster in, RAM port, pixel out, idle)
// Optional build macro WAVE_DISPLAY_GRID_EN: draws a 404040 grid (centre
// row and every 64th column) on unlit window pixels.
// ---------------------------------------------------------------------------
module wave_display #(
    parameter logic [10:0] X_START    = 11'd128,
    parameter logic [9:0]  WIN_HEIGHT = 10'd512,
    parameter logic [23:0] TRACE_RGB  = 24'hFFFFFF
) (
    input  logic           clk,
    input  logic           reset,
    wave_display_if.slave  bus
);
    localparam logic [10:0] X_LAST    = X_START + 11'd511;
    localparam logic [9:0]  VIS_ROWS  = 10'd600;
`ifdef WAVE_DISPLAY_GRID_EN
    localparam logic [23:0] GRID_RGB  = 24'h404040;
`endif

    logic       w_in_win;
    logic [8:0] w_xo;
    logic [7:0] w_prev_eff;
    logic [7:0] w_pc;
    logic [7:0] w_pp;
    logic [7:0] w_lo;
    logic [7:0] w_hi;
    logic       w_lit;
    logic [23:0] w_rgb_next;

    logic       r_active_index;
    logic [7:0] r_prev_sample;
    logic [7:0] r_ys_s1;
    logic       r_in_win_s1;
    logic       r_odd_s1;
    logic       r_first_s1;
`ifdef WAVE_DISPLAY_GRID_EN
    logic       r_grid_col_s1;
`endif
    logic       r_valid_pixel;
    logic [23:0] r_rgb;
    logic       r_idle;

    // Window membership and 9-bit column offset (modulo 512 is all we need).
    assign w_in_win = bus.valid && (bus.x >= X_START) && (bus.x <= X_LAST)
                      && (bus.y < WIN_HEIGHT);
    assign w_xo     = bus.x[8:0] - X_START[8:0];

    assign bus.read_address      = {r_active_index, w_xo[8:1]};
    assign bus.valid_pixel       = r_valid_pixel;
    assign bus.r                 = r_rgb[23:16];
    assign bus.g                 = r_rgb[15:8];
    assign bus.b                 = r_rgb[7:0];
    assign bus.wave_display_idle = r_idle;

    // Idle flag and buffer selection: the half only changes while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle         <= 1'b0;
            r_active_index <= 1'b0;
        end else begin
            r_idle <= (bus.y >= WIN_HEIGHT) || (bus.y >= VIS_ROWS);
            if (r_idle) begin
                r_active_index <= bus.read_index;
            end else begin
                r_active_index <= r_active_index;
            end
        end
    end

    // Stage 1: register pixel position; RAM data for it arrives this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ys_s1     <= 8'd0;
            r_in_win_s1 <= 1'b0;
            r_odd_s1    <= 1'b0;
            r_first_s1  <= 1'b0;
`ifdef WAVE_DISPLAY_GRID_EN
            r_grid_col_s1 <= 1'b0;
`endif
        end else begin
            r_ys_s1     <= bus.y[8:1];
            r_in_win_s1 <= w_in_win;
            r_odd_s1    <= w_xo[0];
            r_first_s1  <= (w_xo == 9'd0);
`ifdef WAVE_DISPLAY_GRID_EN
            r_grid_col_s1 <= (w_xo[5:0] == 6'd0);
`endif
        end
    end

    // Previous-sample register. It is also loaded on the first pixel of a
    // row so the second pixel of sample 0 does not connect to the previous
    // row's last sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_sample <= 8'd0;
        end else if (r_in_win_s1 && (r_odd_s1 || r_first_s1)) begin
            r_prev_sample <= bus.read_value;
        end else begin
            r_prev_sample <= r_prev_sample;
        end
    end

    // Plot rule: lit when the row lies between previous and current sample.
    always_comb begin
        w_prev_eff = r_first_s1 ? bus.read_value : r_prev_sample;
        w_pc       = 8'd255 - bus.read_value;
        w_pp       = 8'd255 - w_prev_eff;
        if (w_pp < w_pc) begin
            w_lo = w_pp;
            w_hi = w_pc;
        end else begin
            w_lo = w_pc;
            w_hi = w_pp;
        end
        w_lit      = r_in_win_s1 && (r_ys_s1 >= w_lo) && (r_ys_s1 <= w_hi);
        w_rgb_next = 24'h000000;
        if (w_lit) begin
            w_rgb_next = TRACE_RGB;
        end else begin
`ifdef WAVE_DISPLAY_GRID_EN
            if (r_in_win_s1 && ((r_ys_s1 == 8'd128) || r_grid_col_s1)) begin
                w_rgb_next = GRID_RGB;
            end else begin
                w_rgb_next = 24'h000000;
            end
`else
            w_rgb_next = 24'h000000;
`endif
        end
    end

    // Stage 2: registered pixel outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_pixel <= 1'b0;
            r_rgb         <= 24'h000000;
        end else begin
            r_valid_pixel <= r_in_win_s1;
            r_rgb         <= w_rgb_next;
        end
    end
endmodule

// File: tb/tb_wave_display.sv
// ---------------------------------------------------------------------------
// tb_wave_display
// Scoreboard bench: the stimulus process pushes the pixel and idle values the
// behavioural model predicts for each raster position; a monitor pops them
// when they are due and compares with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_wave_display;
    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;
    int   disp_half;
    logic [7:0] mem [512];

    typedef struct { int due; logic [24:0] pix; } pix_t;
    typedef struct { int due; bit idle; }         idl_t;
    pix_t pq[$];
    idl_t iq[$];

    wave_display_if bus();

    wave_display dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous sample RAM model.
    always @(posedge clk) bus.read_value <= mem[bus.read_address];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Behavioural pixel model: {valid_pixel, rgb}.
    function automatic logic [24:0] model_pix(input int xi, input int yi, input bit vi, input int half);
        int xo, k, cur, prev, pc, pp, ys, lo, hi;
        if (!vi || xi < 128 || xi > 639 || yi >= 512) return 25'd0;
        xo   = xi - 128;
        k    = xo / 2;
        cur  = mem[half * 256 + k];
        prev = (k == 0) ? cur : mem[half * 256 + k - 1];
        pc   = 255 - cur;
        pp   = 255 - prev;
        ys   = yi / 2;
        lo   = (pc < pp) ? pc : pp;
        hi   = (pc < pp) ? pp : pc;
        if (ys >= lo && ys <= hi) return {1'b1, 24'hFFFFFF};
`ifdef WAVE_DISPLAY_GRID_EN
        if (ys == 128 || (xo % 64) == 0) return {1'b1, 24'h404040};
`endif
        return {1'b1, 24'h000000};
    endfunction

    task automatic drive(input int xi, input int yi, input bit vi);
        pix_t p;
        idl_t q;
        @(posedge clk);
        #1;
        bus.x     = xi[10:0];
        bus.y     = yi[9:0];
        bus.valid = vi;
        p.due = cyc + 2;
        p.pix = model_pix(xi, yi, vi, disp_half);
        pq.push_back(p);
        q.due  = cyc + 1;
        q.idle = (yi >= 512);
        iq.push_back(q);
        if (xi >= 128 && xi <= 639) begin
            #1;
            check("addr_idx", {24'd0, bus.read_address[7:0]}, (xi - 128) / 2);
        end
    endtask

    task automatic scan_row(input int yi, input bit vi);
        for (int xi = 120; xi <= 650; xi++) drive(xi, yi, vi);
    endtask

    task automatic idle_cycles(input int n, input bit ri);
        bus.read_index = ri;
        for (int i = 0; i < n; i++) drive(0, 520, 1'b1);
        disp_half = ri;
    endtask

    // Monitor: compare every output when its expected value comes due.
    initial begin
        pix_t p;
        idl_t q;
        forever begin
            @(negedge clk);
            if (!reset) begin
                while (pq.size() > 0 && pq[0].due <= cyc) begin
                    p = pq.pop_front();
                    check("valid_pixel", {31'd0, bus.valid_pixel}, {31'd0, p.pix[24]});
                    check("rgb", {8'd0, bus.r, bus.g, bus.b}, {8'd0, p.pix[23:0]});
                end
                while (iq.size() > 0 && iq[0].due <= cyc) begin
                    q = iq.pop_front();
                    check("idle", {31'd0, bus.wave_display_idle}, {31'd0, q.idle});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; errors = 0; checks = 0; disp_half = 0;
        reset = 1'b1;
        bus.x = 11'd0; bus.y = 10'd0; bus.valid = 1'b0; bus.read_index = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, bus.valid_pixel}, 32'd0);
        check("rst_rgb", {8'd0, bus.r, bus.g, bus.b}, 32'd0);
        check("rst_idle", {31'd0, bus.wave_display_idle}, 32'd0);
        check("rst_addr8", {31'd0, bus.read_address[8]}, 32'd0);
        reset = 1'b0;

        // Flat 128: row ys=127 fully lit, ys=128 black.
        for (int i = 0; i < 512; i++) mem[i] = 8'd128;
        idle_cycles(4, 1'b0);
        scan_row(254, 1'b1);
        scan_row(256, 1'b1);
        // Flat 0 (pc=255): ys=128 is black, or grid colour with the macro.
        for (int i = 0; i < 512; i++) mem[i] = 8'd0;
        scan_row(256, 1'b1);

        // Ramp: sample k = k in half 1, different data in half 0.
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 8'(255 - i);
            mem[256 + i] = 8'(i);
        end
        idle_cycles(4, 1'b1);
        scan_row(488, 1'b1);
        scan_row(490, 1'b1);
        scan_row(492, 1'b1);
        scan_row(510, 1'b1);

        // Random frames.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(0, 255));
            idle_cycles(4, 1'($urandom_range(0, 1)));
            for (int r = 0; r < 5; r++)
                scan_row($urandom_range(0, 599), ($urandom_range(0, 7) != 0));
        end

        // Buffer selection only changes while idle.
        bus.read_index = 1'b0;
        drive(0, 520, 1'b1);
        bus.read_index = 1'b1;
        drive(0, 520, 1'b1);
        drive(0, 520, 1'b1);
        drive(0, 520, 1'b1);
        disp_half = 1;
        check("idx_load", {31'd0, bus.read_address[8]}, 32'd1);
        for (int xi = 0; xi <= 400; xi++) begin
            if (xi == 200) bus.read_index = 1'b0;
            drive(xi, 0, 1'b1);
            if (xi >= 200 && (xi % 50) == 0)
                check("idx_hold", {31'd0, bus.read_address[8]}, 32'd1);
        end
        drive(0, 512, 1'b1);
        drive(0, 512, 1'b1);
        drive(0, 512, 1'b1);
        disp_half = 0;
        check("idx_swap", {31'd0, bus.read_address[8]}, 32'd0);

        // Reset mid-stream, then resume on a fresh row.
        drive(200, 10, 1'b1);
        drive(201, 10, 1'b1);
        #1;
        reset = 1'b1;
        pq.delete();
        iq.delete();
        #1;
        check("mid_rst_valid", {31'd0, bus.valid_pixel}, 32'd0);
        check("mid_rst_rgb", {8'd0, bus.r, bus.g, bus.b}, 32'd0);
        check("mid_rst_idle", {31'd0, bus.wave_display_idle}, 32'd0);
        check("mid_rst_addr8", {31'd0, bus.read_address[8]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        scan_row(300, 1'b1);
        scan_row(20, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        if (pq.size() != 0 || iq.size() != 0)
            check("drain", pq.size() + iq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wave_display.md
Name: wave_display

Overview:
- Downstream consumer of the wave capture stage.
- Reads the 512-entry double-buffered sample RAM written by the capture stage (read half selected by `read_index`) and converts it into per-pixel colour for the VGA pixel stream.
- Draws a connected waveform trace: 256 samples, each 2 pixels wide, in a 512x512 window.
- Raises `wave_display_idle` while the beam is outside the window, so the capture stage can swap buffers without tearing.

Parameters:
- X_START, 11'd128, first screen column of the waveform window; the window spans X_START..X_START+511.
- WIN_HEIGHT, 10'd512, rows 0..WIN_HEIGHT-1 are the waveform window; rows >= WIN_HEIGHT are idle rows.
- TRACE_RGB, 24'hFFFFFF, colour of lit trace pixels, as {r,g,b}.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- x  in  11  current VGA column
- y  in  10  current VGA row
- valid  in  1  x/y are inside the visible raster
- read_index  in  1  RAM half the capture stage marks as stable for display
- read_value  in  8  RAM data; synchronous RAM, valid 1 cycle after read_address
- read_address  out  9  {active_index, sample_idx} to the sample RAM
- valid_pixel  out  1  r/g/b are driven by this block for this pixel
- r  out  8  red
- g  out  8  green
- b  out  8  blue
- wave_display_idle  out  1  beam is outside the waveform window; buffer swap allowed

Behaviour:
- Reset (async, active-high) clears every register to 0:
  - active_index, prev_sample, pipeline registers, valid_pixel, r/g/b, wave_display_idle.
  - read_address therefore reads {0, sample_idx}.
- Window membership:
  - in_win = valid && x >= X_START && x <= X_START+511 && y < WIN_HEIGHT.
  - xo = x - X_START (9 bits); sample_idx = xo[8:1].
- read_address is combinational: {active_index, sample_idx}. Outside the window it still follows x; the value is don't-care but must not be X.
- active_index:
  - Loaded from read_index on every clock where wave_display_idle = 1.
  - Held constant whenever wave_display_idle = 0, so one frame never mixes halves.
- Pipeline. Stage 1 (cycle N+1) registers y[8:1], in_win, sample_idx, and first = (xo == 0). read_value arriving in N+1 belongs to this pixel.
- Sample register:
  - prev_sample is updated from read_value at the last pixel of each sample (xo[0] == 1 in stage 1).
  - When first = 1, prev_sample is treated as equal to read_value, so there is no line from the previous row's end.
- Plot rule, with ys = stage-1 y[8:1]:
  - pc = 255 - read_value; pp = 255 - prev_sample.
  - Lit when in_win_s1 && min(pp,pc) <= ys <= max(pp,pc).
  - All comparisons are unsigned 8-bit.
- Stage 2 (cycle N+2), registered outputs:
  - valid_pixel = in_win_s1.
  - {r,g,b} = TRACE_RGB if lit, else 24'h000000.
  - Total latency from x/y to pixel outputs is exactly 2 cycles.
- wave_display_idle:
  - Registered: next value = (y >= WIN_HEIGHT) || !valid_rows, where valid_rows means y < 600.
  - High throughout the bottom rows and vertical blanking; low during window rows, including horizontal blanking within them.
- Boundaries:
  - x = X_START+511: last column plotted. X_START+512 is outside the window, with valid_pixel = 0 two cycles later.
  - Flat signal (pp == pc): exactly one row lit per column.
  - read_index toggling mid-window: ignored until the next idle period.
  - Reset mid-frame: outputs drop to 0 immediately; the trace resumes on the next window pixel, with the first pixel per row rule still applying.

Optional Feature:
- WAVE_DISPLAY_GRID_EN.
- When defined: unlit window pixels with ys == 128 (centre line), or with xo[5:0] == 0 (vertical grid every 64 px), output 24'h404040; the trace colour takes priority.
- When undefined: unlit pixels are black; no grid logic is synthesised.

Test Plan:
- Reset asserted mid-stream with x = 200, y = 10 → valid_pixel = 0, rgb = 0, wave_display_idle = 0 within the same cycle; read_address[8] = 0.
- Model RAM with read_value = 8'd128 constant, scan row y = 254 (ys = 127), x = 128..639 → valid_pixel = 1 from the cycle after x = 128 plus 2, every pixel rgb = FFFFFF; row y = 256 → all black.
- Ramp: sample k = k. At x = X_START+2k+1 with k = 10: pp = 246, pc = 245 → ys = 245 and 246 lit, ys = 244 black; check 2-cycle latency.
- Drive y = 520 → wave_display_idle = 1 next cycle. Toggle read_index to 1 → active_index = 1, read_address[8] = 1. Then y = 0, toggle read_index to 0 mid-window → read_address[8] stays 1 until y >= 512.
- x = 127 and x = 640 with y = 0 → valid_pixel = 0 two cycles later. Check read_address bits [7:0] at x = 639 = 255.
- With WAVE_DISPLAY_GRID_EN: flat sample 0 (pc = 255), y = 256 (ys = 128), x = 192 → rgb = 404040; same pixel without the macro → 000000.
